perf_counter_bank: RTL and testbench

- Parametrised bank of NUM_CH event counters for CPU bring-up and performance monitoring (cycles, retired instructions, stalls, ...).
- Each channel has a selectable direction (up/down) and a selectable overflow mode (wrap/saturate), plus a sticky overflow flag and a software load.
- A global snapshot copies all channels atomically into shadow registers, so a multi-counter readout is coherent.
- Sits beside the core; event strobes come from the pipeline, and the load/snapshot/read port comes from the debug/CSR logic.

---
 rtl/perf_cnt_pkg.sv | 14 +
 rtl/perf_counter_bank_if.sv | 32 +++
 rtl/perf_counter_channel.sv | 56 +++++
 rtl/perf_counter_bank.sv | 85 ++++++++
 tb/tb_perf_counter_bank.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/perf_cnt_pkg.sv
// Shared definitions for the performance counter bank.
//   MODE_DOWN / MODE_SAT : bit positions inside a channel's mode vector.
//   sel_width(n)         : select width for n channels (minimum 1 bit).
package perf_cnt_pkg;

  localparam int MODE_DOWN = 0;
  localparam int MODE_SAT  = 1;
  localparam int MODE_W    = 2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// CSR/debug side port of the counter bank: load, snapshot, overflow clear
// and the two read muxes.
//   master : CSR logic (drives ld_*, snap, clr_ovf, rd_sel; reads data)
//   slave  : counter bank
interface perf_counter_bank_if
  import perf_cnt_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = sel_width(NUM_CH);

  logic             ld_en;
  logic [SEL_W-1:0] ld_sel;
  logic [WIDTH-1:0] ld_data;
  logic             snap;
  logic             clr_ovf;
  logic [SEL_W-1:0] rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] live_data;

  modport master (
    output ld_en, ld_sel, ld_data, snap, clr_ovf, rd_sel,
    input  rd_data, live_data
  );

  modport slave (
    input  ld_en, ld_sel, ld_data, snap, clr_ovf, rd_sel,
    output rd_data, live_data
  );

endinterface

// File: rtl/perf_counter_channel.sv
// One event counter: up/down, wrap/saturate, software load.
//   clk, reset_n  : clock, async active-low reset (count -> RESET_VAL)
//   step_i        : count one step this cycle (already gated by enable)
//   mode_i        : [MODE_DOWN] count down, [MODE_SAT] saturate at bound
//   ld_i/ld_data_i: load strobe and value; load beats step
//   cnt_o         : registered count
//   ovf_set_o     : this cycle's step crosses a bound (comb, to top's flags)
module perf_counter_channel
  import perf_cnt_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              ld_i,
  input  logic [WIDTH-1:0]  ld_data_i,
  output logic [WIDTH-1:0]  cnt_o,
  output logic              ovf_set_o
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             down, sat, at_bound;

  assign down     = mode_i[MODE_DOWN];
  assign sat      = mode_i[MODE_SAT];
  assign at_bound = down ? (cnt_q == '0) : (cnt_q == MAX);

  // A load in the same cycle swallows the step, so it cannot overflow.
  assign ovf_set_o = step_i & ~ld_i & at_bound;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_data_i;
    end else if (step_i) begin
      // At a bound the wrap target (MAX->0, 0->MAX) is the bitwise inverse.
      if (at_bound) cnt_d = sat ? cnt_q : ~cnt_q;
      else          cnt_d = down ? (cnt_q - ONE) : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= RST;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH performance counters with atomic snapshot and sticky
// overflow flags.
//   clk, reset_n : clock, async active-low reset
//   en_i         : global count enable (gates steps only)
//   evt_i        : per-channel event strobes
//   mode_down_i  : per-channel count direction (1 = down)
//   mode_sat_i   : per-channel overflow mode (1 = saturate)
//   csr          : load / snapshot / clear / read port (slave side)
//   ovf_o        : sticky per-channel overflow flags
module perf_counter_bank
  import perf_cnt_pkg::*;
#(
  parameter  int          WIDTH     = 32,
  parameter  int          NUM_CH    = 4,
  parameter  int unsigned RESET_VAL = 0,
  localparam int          SEL_W     = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] evt_i,
  input  logic [NUM_CH-1:0] mode_down_i,
  input  logic [NUM_CH-1:0] mode_sat_i,
  perf_counter_bank_if.slave csr,
  output logic [NUM_CH-1:0] ovf_o
);

  logic [NUM_CH-1:0][WIDTH-1:0] cnt;
  logic [NUM_CH-1:0][WIDTH-1:0] shadow_q;
  logic [NUM_CH-1:0]            ovf_set, ovf_q, ovf_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic              ld;
    logic [MODE_W-1:0] mode;

    // An out-of-range ld_sel matches no channel, so the load is dropped.
    assign ld              = csr.ld_en & (csr.ld_sel == SEL_W'(g));
    assign mode[MODE_DOWN] = mode_down_i[g];
    assign mode[MODE_SAT]  = mode_sat_i[g];

    perf_counter_channel #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .step_i    (en_i & evt_i[g]),
      .mode_i    (mode),
      .ld_i      (ld),
      .ld_data_i (csr.ld_data),
      .cnt_o     (cnt[g]),
      .ovf_set_o (ovf_set[g])
    );
  end

  // Set beats clear when both happen in one cycle.
  assign ovf_d = (ovf_q & ~{NUM_CH{csr.clr_ovf}}) | ovf_set;

  // Shadow samples the pre-edge counts, so same-cycle steps/loads are not seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      ovf_q    <= '0;
    end else begin
      if (csr.snap) shadow_q <= cnt;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;

  // Compare-based mux keeps out-of-range selects at zero without indexing
  // past the arrays.
  always_comb begin
    csr.rd_data   = '0;
    csr.live_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (csr.rd_sel == SEL_W'(i)) begin
        csr.rd_data   = shadow_q[i];
        csr.live_data = cnt[i];
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
  localparam int W    = 8;
  localparam int N    = 5;
  localparam int RV   = 1000;
  localparam int MAXV = 255;
  localparam int RVT  = RV % (MAXV + 1);   // 1000 truncated to 8 bits = 232

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         en = 1'b0;
  logic [N-1:0] evt = '0, mdown = '0, msat = '0;
  logic [N-1:0] ovf;

  perf_counter_bank_if #(.WIDTH(W), .NUM_CH(N)) csr ();

  perf_counter_bank #(.WIDTH(W), .NUM_CH(N), .RESET_VAL(RV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_i        (en),
    .evt_i       (evt),
    .mode_down_i (mdown),
    .mode_sat_i  (msat),
    .csr         (csr),
    .ovf_o       (ovf)
  );

  always #20 clk = ~clk;

  int           total = 0, bad = 0;
  int           m_cnt[N], m_sh[N];
  logic [N-1:0] m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = RVT;
      m_sh[i]  = 0;
    end
    m_ovf = '0;
  endtask

  // Walks every select value, including out-of-range ones (5..7).
  task automatic check_all(input string tag);
    chk($sformatf("%s ovf", tag), 32'(ovf), 32'(m_ovf));
    for (int s = 0; s < 8; s++) begin
      csr.rd_sel = 3'(s);
      #1;
      chk($sformatf("%s live%0d", tag, s), 32'(csr.live_data), (s < N) ? 32'(m_cnt[s]) : 32'd0);
      chk($sformatf("%s shadow%0d", tag, s), 32'(csr.rd_data), (s < N) ? 32'(m_sh[s]) : 32'd0);
    end
  endtask

  // Reference: next state from the behavioural rules, applied at the edge.
  task automatic tick(input string tag);
    int           nc[N];
    logic [N-1:0] setf;
    for (int i = 0; i < N; i++) begin
      int v;
      nc[i]   = m_cnt[i];
      setf[i] = 1'b0;
      if (csr.ld_en && int'(csr.ld_sel) == i) begin
        nc[i] = int'(csr.ld_data);
      end else if (en && evt[i]) begin
        v = mdown[i] ? m_cnt[i] - 1 : m_cnt[i] + 1;
        if (v < 0 || v > MAXV) begin
          setf[i] = 1'b1;
          v = msat[i] ? m_cnt[i] : (v + MAXV + 1) % (MAXV + 1);
        end
        nc[i] = v;
      end
    end
    if (csr.snap) for (int i = 0; i < N; i++) m_sh[i] = m_cnt[i];
    m_ovf = (csr.clr_ovf ? '0 : m_ovf) | setf;
    for (int i = 0; i < N; i++) m_cnt[i] = nc[i];
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic load(input int ch, input int val);
    csr.ld_en   = 1'b1;
    csr.ld_sel  = 3'(ch);
    csr.ld_data = 8'(val);
    tick($sformatf("load%0d", ch));
    csr.ld_en   = 1'b0;
  endtask

  task automatic exp_live(input string tag, input int ch, input int val);
    csr.rd_sel = 3'(ch);
    #1;
    chk(tag, 32'(csr.live_data), 32'(val));
  endtask

  task automatic exp_shadow(input string tag, input int ch, input int val);
    csr.rd_sel = 3'(ch);
    #1;
    chk(tag, 32'(csr.rd_data), 32'(val));
  endtask

  initial begin
    csr.ld_en = 1'b0; csr.ld_sel = '0; csr.ld_data = '0;
    csr.snap = 1'b0;  csr.clr_ovf = 1'b0; csr.rd_sel = '0;

    // Reset, released before the first edge
    #1 reset_n = 1'b0;
    model_reset();
    #1 check_all("reset");
    exp_live("reset val truncated", 0, 232);
    #1 reset_n = 1'b1;

    // Counting from RESET_VAL; shadow stays 0 without snap
    en = 1'b1; evt = 5'b00001;
    repeat (5) tick("count ch0");
    exp_live("ch0 after 5", 0, 237);
    exp_shadow("ch0 shadow no snap", 0, 0);
    chk("ovf none", 32'(ovf), 32'd0);
    evt = '0;

    // ch1 up/wrap
    load(1, 'hFE);
    evt = 5'b00010;
    tick("wrap1"); exp_live("wrap FF", 1, 'hFF); chk("wrap ovf pre", 32'(ovf[1]), 32'd0);
    tick("wrap2"); exp_live("wrap 00", 1, 'h00); chk("wrap ovf", 32'(ovf[1]), 32'd1);
    tick("wrap3"); exp_live("wrap 01", 1, 'h01);
    evt = '0;

    // ch1 up/sat (load together with clr_ovf)
    msat[1] = 1'b1; csr.clr_ovf = 1'b1;
    load(1, 'hFE);
    csr.clr_ovf = 1'b0;
    chk("sat ovf cleared", 32'(ovf[1]), 32'd0);
    evt = 5'b00010;
    repeat (3) tick("sat up");
    exp_live("sat hold FF", 1, 'hFF);
    chk("sat ovf", 32'(ovf[1]), 32'd1);
    evt = '0;

    // ch2 down/sat then down/wrap
    mdown[2] = 1'b1; msat[2] = 1'b1;
    load(2, 1);
    evt = 5'b00100;
    repeat (3) tick("sat down");
    exp_live("sat hold 0", 2, 0);
    chk("sat down ovf", 32'(ovf[2]), 32'd1);
    msat[2] = 1'b0;
    tick("wrap down");
    exp_live("wrap down FF", 2, 'hFF);
    evt = '0; mdown = '0; msat = '0;

    // Snapshot with same-cycle steps on every channel
    for (int i = 0; i < N; i++) load(i, 10 * (i + 1));
    csr.snap = 1'b1; evt = '1;
    tick("snap+step");
    csr.snap = 1'b0; evt = '0;
    for (int i = 0; i < N; i++) begin
      exp_shadow($sformatf("snap old %0d", i), i, 10 * (i + 1));
      exp_live($sformatf("live new %0d", i), i, 10 * (i + 1) + 1);
    end

    // Load beats step; out-of-range load dropped
    evt = 5'b00001; csr.ld_en = 1'b1; csr.ld_sel = 3'd0; csr.ld_data = 8'd7;
    tick("load vs step");
    csr.ld_en = 1'b0; evt = '0;
    exp_live("load wins", 0, 7);
    load(6, 99);

    // Set beats clear, then clear alone
    load(3, 'hFF);
    evt = 5'b01000; csr.clr_ovf = 1'b1;
    tick("set vs clr");
    chk("set beats clr", 32'(ovf), 32'b01000);
    evt = '0;
    tick("clr alone");
    chk("clr alone", 32'(ovf), 32'd0);
    csr.clr_ovf = 1'b0;

    // en=0 blocks steps
    en = 1'b0; evt = '1;
    repeat (2) tick("en off");
    exp_live("en off hold", 0, 7);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      en          = ($urandom_range(0, 3) != 0);
      evt         = N'($urandom);
      mdown       = N'($urandom);
      msat        = N'($urandom);
      csr.ld_en   = ($urandom_range(0, 5) == 0);
      csr.ld_sel  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       csr.ld_data = 8'h00;
        1:       csr.ld_data = 8'h01;
        2:       csr.ld_data = 8'hFE;
        3:       csr.ld_data = 8'hFF;
        default: csr.ld_data = 8'($urandom);
      endcase
      csr.snap    = ($urandom_range(0, 3) == 0);
      csr.clr_ovf = ($urandom_range(0, 7) == 0);
      tick("rand");
    end
    csr.ld_en = 1'b0; csr.snap = 1'b1; csr.clr_ovf = 1'b0;
    en = 1'b1; evt = '1;
    tick("pre reset");
    csr.snap = 1'b0;

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all("async reset");
    #2 reset_n = 1'b1;
    repeat (3) tick("after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
